hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. Shadows destination/source register numbers of
//  instructions in EX, MEM and WB, stalls IF/ID on load-use and HI/LO-busy hazards, and drives the
//  EX operand-forwarding selects. Sits beside the ID/EX pipeline register; owns no datapath.
// PARAMETERS
//  REG_W       5   register-number width (32 GPRs)
//  MULDIV_LAT  32  cycles a mult/div occupies HI/LO (>=2); counter width = $clog2(MULDIV_LAT+1)
// PORTS
//  clk            in   1      core clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  id_valid       in   1      ID holds a real instruction
//  id_rs, id_rt   in   REG_W  ID source register numbers
//  id_use_rs/rt   in   1      ID instruction actually reads rs / rt
//  id_dst         in   REG_W  ID destination register number
//  id_wr          in   1      ID instruction writes id_dst
//  id_load        in   1      ID instruction is a load (result available after MEM)
//  id_muldiv      in   1      ID instruction starts mult/div
//  id_hilo_rd     in   1      ID instruction reads HI/LO (mfhi/mflo) or starts mult/div
//  flush          in   1      branch/jump redirect: kill the instruction leaving ID
//  stall          out  1      hold PC and IF/ID; ID/EX loads a bubble
//  fwd_a, fwd_b   out  2      EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  muldiv_busy    out  1      HI/LO unit occupied
// BEHAVIOUR
//  - State: per stage S in {EX,MEM,WB}: S_dst, S_wr, S_load; EX also ex_rs, ex_rt, ex_use_rs/rt; busy_cnt.
//  - Reset (async, rst_n=0): all *_wr/*_load/*_use = 0, all reg numbers 0, busy_cnt = 0.
//    Outputs then: stall=0, fwd_a=fwd_b=00, muldiv_busy=0. Takes effect mid-operation immediately.
//  - Match rule: match(x,y) = (x==y) && (x!=0) && writer_wr. Register $0 never matches.
//  - Load-use: lu = id_valid && ex_load && ex_wr && ((id_use_rs && match(id_rs,ex_dst)) ||
//    (id_use_rt && match(id_rt,ex_dst))). Exactly one stall cycle per load-use (next cycle load is in MEM).
//  - HI/LO: hz = id_valid && id_hilo_rd && muldiv_busy.
//  - stall = (lu || hz) && !flush  (combinational from state + ID inputs; flush dominates).
//  - Each posedge: WB<=MEM, MEM<=EX (always advance). EX <= bubble (all flags 0) if stall || flush || !id_valid,
//    else EX <= ID fields.
//  - busy_cnt: loads MULDIV_LAT when an ID mult/div enters EX (id_muldiv && advance); else decrements to 0
//    and saturates. muldiv_busy = (busy_cnt != 0). New mult/div while busy stalls (id_hilo_rd set) until 0.
//  - Forwarding (combinational on EX state): fwd_a = 01 if ex_use_rs && match(ex_rs,mem_dst) && !mem_load;
//    else 10 if ex_use_rs && match(ex_rs,wb_dst); else 00. fwd_b identical on ex_rt.
//    MEM (younger) has priority over WB. Load in MEM never forwards 01 (load-use stall guarantees it is in WB).
//  - Latency: stall/fwd are same-cycle combinational; scoreboard updates one cycle after ID.
// STRUCTURE
//  - Package hazard_pkg: REG_W, fwd select enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10),
//    stage-shadow struct {dst, wr, load}.
//  - Sub-module reg_match: REG_W-bit equality with zero-register exclusion and write-enable gate;
//    instantiated 2 (load-use) + 4 (forwarding) times.
//  - Counter and stage shadows in this module; no other hierarchy.
// TESTING
//  1 lw $8 then add $9,$8,$2 back-to-back -> stall=1 exactly one cycle, then fwd_a=10 on add in EX.
//  2 add $8 then sub $10,$8,$8 -> no stall, fwd_a=fwd_b=01; insert one nop between -> fwd_a=fwd_b=10.
//  3 add $0,... then or $3,$0,$0 -> no stall, fwd=00; add $5 in MEM and WB both -> fwd selects 01.
//  4 mult then mflo after 3 cycles (MULDIV_LAT=8) -> stall until busy_cnt=0, mflo enters EX the cycle after.
//  5 load-use stall with flush=1 same cycle -> stall=0, EX gets bubble, no fwd to flushed op.
//  6 rst_n low during a mult and load-use -> stall, muldiv_busy, fwd drop to 0 asynchronously; recover clean.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared register width, forwarding-select encoding and pipeline stage shadow type
package hazard_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             wr;
    logic             load;
  } stage_t;
  localparam stage_t BUBBLE = '0;
endpackage

// File: rtl/hazard_scoreboard_reg_match.sv
// reg_match: register-number equality gated by the writer's enable; $0 never matches
module reg_match
  import hazard_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_wr,
  output logic         o_match
);
  assign o_match = i_wr && (i_a == i_b) && (i_a != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadows EX/MEM/WB register usage, stalls IF/ID on load-use and HI/LO-busy
// hazards, and drives the EX operand-forwarding selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             id_muldiv,
  input  logic             id_hilo_rd,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             muldiv_busy
);
  localparam int CW = $clog2(MULDIV_LAT + 1);
  stage_t           r_ex, r_mem, r_wb;
  logic [REG_W-1:0] r_ex_rs, r_ex_rt;
  logic             r_ex_use_rs, r_ex_use_rt;
  logic [CW-1:0]    r_busy_cnt;
  logic             w_lu_rs, w_lu_rt, w_a_mem, w_a_wb, w_b_mem, w_b_wb;
  logic             w_lu, w_hz, w_adv;
  reg_match u_lu_rs (.i_a(id_rs),   .i_b(r_ex.dst),  .i_wr(r_ex.wr),  .o_match(w_lu_rs));
  reg_match u_lu_rt (.i_a(id_rt),   .i_b(r_ex.dst),  .i_wr(r_ex.wr),  .o_match(w_lu_rt));
  reg_match u_a_mem (.i_a(r_ex_rs), .i_b(r_mem.dst), .i_wr(r_mem.wr), .o_match(w_a_mem));
  reg_match u_a_wb  (.i_a(r_ex_rs), .i_b(r_wb.dst),  .i_wr(r_wb.wr),  .o_match(w_a_wb));
  reg_match u_b_mem (.i_a(r_ex_rt), .i_b(r_mem.dst), .i_wr(r_mem.wr), .o_match(w_b_mem));
  reg_match u_b_wb  (.i_a(r_ex_rt), .i_b(r_wb.dst),  .i_wr(r_wb.wr),  .o_match(w_b_wb));
  assign muldiv_busy = r_busy_cnt != '0;
  assign w_lu  = id_valid && r_ex.load && r_ex.wr &&
                 ((id_use_rs && w_lu_rs) || (id_use_rt && w_lu_rt));
  assign w_hz  = id_valid && id_hilo_rd && muldiv_busy;
  assign stall = (w_lu || w_hz) && !flush;
  assign w_adv = id_valid && !stall && !flush;
  // A load sitting in MEM has no result yet; the load-use stall pushes it to WB first
  assign fwd_a = (r_ex_use_rs && w_a_mem && !r_mem.load) ? FWD_MEM :
                 (r_ex_use_rs && w_a_wb) ? FWD_WB : FWD_RF;
  assign fwd_b = (r_ex_use_rt && w_b_mem && !r_mem.load) ? FWD_MEM :
                 (r_ex_use_rt && w_b_wb) ? FWD_WB : FWD_RF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= BUBBLE;
      r_mem       <= BUBBLE;
      r_wb        <= BUBBLE;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
      r_busy_cnt  <= '0;
    end else begin
      r_wb        <= r_mem;
      r_mem       <= r_ex;
      r_ex        <= w_adv ? stage_t'{dst: id_dst, wr: id_wr, load: id_load} : BUBBLE;
      r_ex_rs     <= w_adv ? id_rs : '0;
      r_ex_rt     <= w_adv ? id_rt : '0;
      r_ex_use_rs <= w_adv && id_use_rs;
      r_ex_use_rt <= w_adv && id_use_rt;
      r_busy_cnt  <= (w_adv && id_muldiv) ? CW'(MULDIV_LAT) : r_busy_cnt - CW'(muldiv_busy);
    end
  end
endmodule
